// File: rtl/pid_regulator_if.sv
// Bundles the control/sample inputs and the duty outputs of pid_regulator.
// master: the side driving samples and gains; slave: the regulator itself.
interface pid_regulator_if #(
  parameter int DW    = 12,
  parameter int KW    = 16,
  parameter int OUT_W = 15
);
  logic             en;
  logic             sample;
  logic [DW-1:0]    setpoint;
  logic [DW-1:0]    measured;
  logic [KW-1:0]    kp;
  logic [KW-1:0]    ki;
  logic [KW-1:0]    kd;
  logic [OUT_W-1:0] duty;
  logic             duty_valid;
  logic             busy;

  modport master (
    output en, sample, setpoint, measured, kp, ki, kd,
    input  duty, duty_valid, busy
  );

  modport slave (
    input  en, sample, setpoint, measured, kp, ki, kd,
    output duty, duty_valid, busy
  );
endinterface

// File: rtl/pid_regulator.sv
// Discrete PID regulator producing a saturated PWM duty word, one shared multiplier sequenced by an FSM.
// Define PID_DERIV_EN to include the derivative term (MUL_D state, sample-to-duty latency 5 instead of 4).
module pid_regulator #(
  parameter int DW    = 12,
  parameter int KW    = 16,
  parameter int IW    = 32,
  parameter int OUT_W = 15
) (
  input  logic           clk1,
  input  logic           rst,
  pid_regulator_if.slave bus
);
  localparam int EW = DW + 1;        // error width
  localparam int MW = DW + 2;        // multiplier data operand, holds e - e_prev
  localparam int PW = KW + 1 + MW;   // product width
  localparam int CW = IW + 1;
  localparam int UW = IW + 2;
  localparam logic signed [CW-1:0] I_MAX = {2'b00, {(IW-1){1'b1}}};
  localparam logic signed [CW-1:0] I_MIN = -I_MAX;
  localparam logic signed [UW-1:0] U_MAX = {{(UW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_MUL_P,
    S_MUL_I,
`ifdef PID_DERIV_EN
    S_MUL_D,
`endif
    S_SUM
  } state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           sp_q, sp_d;
  logic [DW-1:0]           ms_q, ms_d;
  logic [KW-1:0]           kp_q, kp_d;
  logic [KW-1:0]           ki_q, ki_d;
  logic signed [EW-1:0]    e_q, e_d;
  logic signed [PW-1:0]    p_q, p_d;
  logic signed [IW-1:0]    acc_q, acc_d;
  logic                    sat_q, sat_d;
  logic                    sat_hi_q, sat_hi_d;
  logic [OUT_W-1:0]        duty_q, duty_d;
  logic                    duty_valid_q, duty_valid_d;
  logic                    busy_q, busy_d;
  logic signed [PW-1:0]    d_term;
`ifdef PID_DERIV_EN
  logic [KW-1:0]           kd_q, kd_d;
  logic signed [EW-1:0]    e_prev_q, e_prev_d;
  logic signed [PW-1:0]    d_q, d_d;
  assign d_term = d_q;
`else
  logic                    unused_kd;
  assign unused_kd = ^bus.kd;
  assign d_term    = '0;
`endif

  logic signed [KW:0]      mul_a;
  logic signed [MW-1:0]    mul_b;
  logic signed [PW-1:0]    prod;
  logic signed [CW-1:0]    cand;
  logic signed [IW-1:0]    cand_sat;
  logic signed [UW-1:0]    u_sum;
  logic signed [UW-1:0]    u_sh;
  logic                    commit;

  // Operand select for the single multiplier shared by the P, I and D passes.
  always_comb begin
    mul_a = $signed({1'b0, kp_q});
    mul_b = MW'(e_q);
    case (state_q)
      S_MUL_I: mul_a = $signed({1'b0, ki_q});
`ifdef PID_DERIV_EN
      S_MUL_D: begin
        mul_a = $signed({1'b0, kd_q});
        mul_b = MW'(e_q) - MW'(e_prev_q);
      end
`endif
      default: ;
    endcase
  end

  assign prod = mul_a * mul_b;

  always_comb begin
    cand     = CW'(acc_q) + CW'(prod);
    cand_sat = cand[IW-1:0];
    if (cand > I_MAX) begin
      cand_sat = I_MAX[IW-1:0];
    end else if (cand < I_MIN) begin
      cand_sat = I_MIN[IW-1:0];
    end
  end

  // After a clamped pass the integrator may only move back toward the linear range.
  assign commit = !sat_q || (sat_hi_q ? e_q[EW-1] : (!e_q[EW-1] && (e_q != '0)));

  assign u_sum = UW'(p_q) + UW'(acc_q) + UW'(d_term);
  assign u_sh  = u_sum >>> 8;

  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    ms_d         = ms_q;
    kp_d         = kp_q;
    ki_d         = ki_q;
    e_d          = e_q;
    p_d          = p_q;
    acc_d        = acc_q;
    sat_d        = sat_q;
    sat_hi_d     = sat_hi_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    busy_d       = busy_q;
`ifdef PID_DERIV_EN
    kd_d         = kd_q;
    e_prev_d     = e_prev_q;
    d_d          = d_q;
`endif
    if (!bus.en) begin
      state_d  = S_IDLE;
      acc_d    = '0;
      sat_d    = 1'b0;
      sat_hi_d = 1'b0;
      duty_d   = '0;
      busy_d   = 1'b0;
`ifdef PID_DERIV_EN
      e_prev_d = '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.sample) begin
            sp_d    = bus.setpoint;
            ms_d    = bus.measured;
            kp_d    = bus.kp;
            ki_d    = bus.ki;
`ifdef PID_DERIV_EN
            kd_d    = bus.kd;
`endif
            busy_d  = 1'b1;
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          e_d     = $signed({1'b0, sp_q}) - $signed({1'b0, ms_q});
          state_d = S_MUL_P;
        end
        S_MUL_P: begin
          p_d     = prod;
          state_d = S_MUL_I;
        end
        S_MUL_I: begin
          if (commit) begin
            acc_d = cand_sat;
          end
`ifdef PID_DERIV_EN
          state_d = S_MUL_D;
`else
          state_d = S_SUM;
`endif
        end
`ifdef PID_DERIV_EN
        S_MUL_D: begin
          d_d      = prod;
          e_prev_d = e_q;
          state_d  = S_SUM;
        end
`endif
        S_SUM: begin
          if (u_sh[UW-1]) begin
            duty_d   = '0;
            sat_d    = 1'b1;
            sat_hi_d = 1'b0;
          end else if (u_sh > U_MAX) begin
            duty_d   = '1;
            sat_d    = 1'b1;
            sat_hi_d = 1'b1;
          end else begin
            duty_d   = u_sh[OUT_W-1:0];
            sat_d    = 1'b0;
            sat_hi_d = 1'b0;
          end
          duty_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sp_q         <= '0;
      ms_q         <= '0;
      kp_q         <= '0;
      ki_q         <= '0;
      e_q          <= '0;
      p_q          <= '0;
      acc_q        <= '0;
      sat_q        <= 1'b0;
      sat_hi_q     <= 1'b0;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      busy_q       <= 1'b0;
`ifdef PID_DERIV_EN
      kd_q         <= '0;
      e_prev_q     <= '0;
      d_q          <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      ms_q         <= ms_d;
      kp_q         <= kp_d;
      ki_q         <= ki_d;
      e_q          <= e_d;
      p_q          <= p_d;
      acc_q        <= acc_d;
      sat_q        <= sat_d;
      sat_hi_q     <= sat_hi_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      busy_q       <= busy_d;
`ifdef PID_DERIV_EN
      kd_q         <= kd_d;
      e_prev_q     <= e_prev_d;
      d_q          <= d_d;
`endif
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_pid_regulator.sv
// Randomized and directed bench for pid_regulator, checked every cycle against a pass-level PID model.
module tb_pid_regulator;
  localparam int DW    = 12;
  localparam int KW    = 16;
  localparam int IW    = 32;
  localparam int OUT_W = 15;
`ifdef PID_DERIV_EN
  localparam int LAT   = 5;
  localparam int D_EXP = 200;
`else
  localparam int LAT   = 4;
  localparam int D_EXP = 0;
`endif
  localparam longint I_LIM = 64'sd2147483647;
  localparam longint U_LIM = 64'sd32767;

  logic clk1 = 1'b0;
  logic rst;
  always #5 clk1 = ~clk1;

  pid_regulator_if #(.DW(DW), .KW(KW), .OUT_W(OUT_W)) bus ();

  pid_regulator #(.DW(DW), .KW(KW), .IW(IW), .OUT_W(OUT_W)) dut (
    .clk1 (clk1),
    .rst  (rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  // Pass-level reference: what the regulator should show after each clock edge.
  longint m_acc = 0, m_eprev = 0;
  bit     m_sat = 1'b0, m_sat_hi = 1'b0;
  int     m_cnt = 0;
  int     m_duty = 0;
  bit     m_valid = 1'b0, m_busy = 1'b0;
  longint l_sp, l_ms, l_kp, l_ki, l_kd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 0; m_eprev = 0; m_sat = 1'b0; m_sat_hi = 1'b0;
    m_cnt = 0; m_duty = 0; m_valid = 1'b0; m_busy = 1'b0;
  endtask

  task automatic finish_pass();
    longint e, p, cand, d, u;
    e = l_sp - l_ms;
    p = l_kp * e;
    cand = m_acc + l_ki * e;
    if (cand > I_LIM) cand = I_LIM;
    if (cand < -I_LIM) cand = -I_LIM;
    if (!m_sat || (m_sat_hi && e < 0) || (!m_sat_hi && e > 0)) m_acc = cand;
`ifdef PID_DERIV_EN
    d = l_kd * (e - m_eprev);
    m_eprev = e;
`else
    d = 0;
`endif
    u = (p + m_acc + d) >>> 8;
    if (u < 0) begin
      m_duty = 0; m_sat = 1'b1; m_sat_hi = 1'b0;
    end else if (u > U_LIM) begin
      m_duty = int'(U_LIM); m_sat = 1'b1; m_sat_hi = 1'b1;
    end else begin
      m_duty = int'(u); m_sat = 1'b0; m_sat_hi = 1'b0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_clear();
    end else if (!bus.en) begin
      model_clear();
    end else begin
      m_valid = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          finish_pass();
          m_valid = 1'b1;
          m_busy  = 1'b0;
        end
      end else if (bus.sample) begin
        l_sp = longint'(bus.setpoint); l_ms = longint'(bus.measured);
        l_kp = longint'(bus.kp); l_ki = longint'(bus.ki); l_kd = longint'(bus.kd);
        m_cnt  = LAT;
        m_busy = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk1);
    model_step();
  end

  initial forever begin
    @(negedge clk1);
    if (checking) begin
      check("cyc duty", 32'(bus.duty), 32'(m_duty));
      check("cyc duty_valid", 32'(bus.duty_valid), 32'(m_valid));
      check("cyc busy", 32'(bus.busy), 32'(m_busy));
    end
  end

  // One pass with literal expectation; exp_duty < 0 leaves the value to the cycle checker.
  task automatic run_pass(input string name, input int sp, input int ms, input int kp,
                          input int ki, input int kd, input int exp_duty);
    int cyc;
    @(negedge clk1);
    bus.setpoint = 12'(sp); bus.measured = 12'(ms);
    bus.kp = 16'(kp); bus.ki = 16'(ki); bus.kd = 16'(kd);
    bus.sample = 1'b1;
    @(negedge clk1);
    bus.sample = 1'b0;
    cyc = 0;
    while (bus.duty_valid !== 1'b1 && cyc < 20) begin
      @(negedge clk1);
      cyc++;
    end
    check({name, " latency"}, 32'(cyc), 32'(LAT));
    if (exp_duty >= 0) check({name, " duty"}, 32'(bus.duty), 32'(exp_duty));
    $display("[TB] pass %s: sp=%0d ms=%0d duty=%0d after %0d cycles", name, sp, ms, bus.duty, cyc);
  endtask

  task automatic clear_pulse();
    @(negedge clk1);
    bus.en = 1'b0;
    @(negedge clk1);
    check("en-clear duty", 32'(bus.duty), 32'd0);
    bus.en = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.sample = 1'b0;
    bus.setpoint = '0; bus.measured = '0;
    bus.kp = '0; bus.ki = '0; bus.kd = '0;
    @(negedge clk1);
    @(negedge clk1);
    checking = 1'b1;
    check("reset duty", 32'(bus.duty), 32'd0);
    check("reset duty_valid", 32'(bus.duty_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    bus.en = 1'b1;

    run_pass("prop", 1000, 0, 16'h0100, 0, 0, 1000);
    run_pass("clamp hi", 4095, 0, 16'h1000, 0, 0, 32767);
    run_pass("clamp lo", 0, 500, 16'h1000, 0, 0, 0);

    clear_pulse();
    for (int i = 1; i <= 4; i++) run_pass("integ", 100, 0, 0, 16'h0080, 0, 50 * i);
    clear_pulse();
    run_pass("integ restart", 100, 0, 0, 16'h0080, 0, 50);

    clear_pulse();
    for (int i = 0; i < 3; i++) run_pass("windup big", 4095, 0, 0, 16'h7FFF, 0, 32767);
    run_pass("windup big neg", 0, 10, 0, 16'h7FFF, 0, -1);
    clear_pulse();
    run_pass("windup 1", 4095, 0, 0, 16'h0900, 0, 32767);
    run_pass("windup 2", 4095, 0, 0, 16'h0900, 0, 32767);
    run_pass("windup release", 0, 500, 0, 16'h0900, 0, 32355);

    clear_pulse();
    run_pass("deriv e0", 0, 0, 0, 0, 16'h0100, 0);
    run_pass("deriv step", 200, 0, 0, 0, 16'h0100, D_EXP);
    run_pass("deriv flat", 200, 0, 0, 0, 16'h0100, 0);

    run_pass("pre reset", 777, 0, 16'h0100, 0, 0, 777);
    @(negedge clk1);
    bus.setpoint = 12'd300; bus.measured = '0;
    bus.kp = 16'h0100; bus.ki = '0; bus.kd = '0;
    bus.sample = 1'b1;
    @(negedge clk1);
    bus.sample = 1'b0;
    @(negedge clk1);
    bus.sample = 1'b1;
    @(negedge clk1);
    bus.sample = 1'b0;
    rst = 1'b1;
    @(negedge clk1);
    check("overlap rst busy", 32'(bus.busy), 32'd0);
    check("overlap rst duty", 32'(bus.duty), 32'd0);
    check("overlap rst valid", 32'(bus.duty_valid), 32'd0);
    rst = 1'b0;
    @(negedge clk1);
    check("overlap no valid", 32'(bus.duty_valid), 32'd0);
    run_pass("after reset", 300, 0, 16'h0100, 0, 0, 300);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk1);
      rst          = ($urandom_range(0, 299) == 0);
      bus.en       = ($urandom_range(0, 99) != 0);
      bus.sample   = ($urandom_range(0, 2) == 0);
      bus.setpoint = 12'($urandom_range(0, 4095));
      bus.measured = 12'($urandom_range(0, 4095));
      if (c < 2000) begin
        bus.kp = 16'($urandom_range(0, 16'h0200));
        bus.ki = 16'($urandom_range(0, 16'h0080));
        bus.kd = 16'($urandom_range(0, 16'h0200));
      end else begin
        bus.kp = 16'($urandom_range(0, 16'hFFFF));
        bus.ki = 16'($urandom_range(0, 16'hFFFF));
        bus.kd = 16'($urandom_range(0, 16'hFFFF));
      end
    end
    @(negedge clk1);
    rst = 1'b0; bus.en = 1'b1; bus.sample = 1'b0;
    repeat (8) @(negedge clk1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
